// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flushes and multi-cycle multiply freeze.
// Optional perf counters are built only when HAZARD_PERF_EN is defined.
module hazard_ctrl #(
   parameter int unsigned MUL_CYCLES = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [4:0]  id_rsaddr_i,
   input  logic [4:0]  id_rtaddr_i,
   input  logic        ex_memread_i,
   input  logic [4:0]  ex_rtaddr_i,
   input  logic        ex_mul_i,
   input  logic        branch_taken_i,
   output logic        pc_write_o,
   output logic        if_id_write_o,
   output logic        if_id_flush_o,
   output logic        id_ex_write_o,
   output logic        id_ex_bubble_o,
   output logic        ex_mem_bubble_o,
   output logic        mul_busy_o,
   output logic        mul_done_o,
   output logic [31:0] stall_cycles_o,
   output logic [31:0] flush_count_o
);

   localparam int unsigned CntW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
   localparam logic [CntW-1:0] CntLoad = CntW'(MUL_CYCLES - 2);

   typedef enum logic {StIdle, StMulBusy} state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            freeze;
   logic            loaduse;

   always_comb begin
      freeze  = ((state_q == StIdle) && ex_mul_i) || ((state_q == StMulBusy) && (cnt_q != '0));
      loaduse = ex_memread_i && (ex_rtaddr_i != 5'd0) &&
                ((ex_rtaddr_i == id_rsaddr_i) || (ex_rtaddr_i == id_rtaddr_i));
   end

   // ex_mul_i is ignored while busy so the held multiply cannot retrigger.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (ex_mul_i) begin
               state_d = StMulBusy;
               cnt_d   = CntLoad;
            end
         end
         StMulBusy: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      pc_write_o      = 1'b1;
      if_id_write_o   = 1'b1;
      if_id_flush_o   = 1'b0;
      id_ex_write_o   = 1'b1;
      id_ex_bubble_o  = 1'b0;
      ex_mem_bubble_o = 1'b0;
      mul_busy_o      = 1'b0;
      mul_done_o      = 1'b0;
      if (rst_i) begin
         if_id_flush_o   = 1'b1;
         id_ex_bubble_o  = 1'b1;
         ex_mem_bubble_o = 1'b1;
      end else if (freeze) begin
         pc_write_o      = 1'b0;
         if_id_write_o   = 1'b0;
         id_ex_write_o   = 1'b0;
         ex_mem_bubble_o = 1'b1;
         mul_busy_o      = 1'b1;
      end else begin
         mul_done_o = (state_q == StMulBusy);
         if (loaduse) begin
            pc_write_o     = 1'b0;
            if_id_write_o  = 1'b0;
            id_ex_bubble_o = 1'b1;
         end else if (branch_taken_i) begin
            if_id_flush_o = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= StIdle;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

`ifdef HAZARD_PERF_EN
   logic [31:0] stall_q, flush_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         if (!pc_write_o) stall_q <= stall_q + 32'd1;
         if (if_id_flush_o) flush_q <= flush_q + 32'd1;
      end
   end

   assign stall_cycles_o = stall_q;
   assign flush_count_o  = flush_q;
`else
   assign stall_cycles_o = '0;
   assign flush_count_o  = '0;
`endif

endmodule
